// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample feeder: default sample width,
// pacing counter width and the feeder state encoding.
package fir_pkg;

    localparam int SAMPLE_WIDTH = 8;
    localparam int PACE_WIDTH   = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/sample_skid_buf.sv
// Two-entry FIFO-ordered prefetch buffer between the async FIFO and the
// sample pacer; supports a push and a pop on the same edge.
module sample_skid_buf
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    // NOTE: the data slots are not reset; occ alone decides which slots hold live samples.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (occ == 2'd0) slot0 <= push_data;
                else             slot1 <= push_data;
            end
            2'b01: slot0 <= slot1;
            2'b11: begin
                if (occ == 2'd1) begin
                    slot0 <= push_data;
                end else begin
                    slot0 <= slot1;
                    slot1 <= push_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= 2'd0;
        end else if (push && !pop) begin
            occ <= occ + 2'd1;
        end else if (pop && !push) begin
            occ <= occ - 2'd1;
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fir_sample_feeder.sv
// FIR-domain reader of the show-ahead async FIFO: primes a 2-entry buffer, then
// emits one sample strobe every DIV clocks, stuffing zeros on underrun.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int DIV   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_inc,
    output logic [WIDTH-1:0] o_sample,
    output logic             o_sample_valid,
    output logic             o_underrun,
    input  logic             i_clr_underrun,
    output logic [15:0]      o_sample_cnt
);

    feeder_state_t         state;
    feeder_state_t         state_next;
    logic [PACE_WIDTH-1:0] pace;
    logic [1:0]            occ;
    logic [WIDTH-1:0]      head;
    logic                  tick;
    logic                  pop;
    logic                  push;

    sample_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (i_fifo_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_next = state;
        tick       = 1'b0;
        if (state == RUN) tick = (pace == PACE_WIDTH'(DIV - 1));
        pop  = tick && (occ != 2'd0);
        // A pop at a tick frees a slot on the same edge, so a full buffer may still refill.
        push = !i_rst && !i_fifo_empty && ((occ < 2'd2) || pop);
        if (state == FILL && occ == 2'd1 && push) state_next = RUN;
    end

    assign o_fifo_rd_inc = push;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FILL;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || state != RUN || tick) pace <= '0;
        else                               pace <= pace + PACE_WIDTH'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_underrun     <= 1'b0;
            o_sample_cnt   <= 16'd0;
        end else begin
            o_sample_valid <= tick;
            if (tick) o_sample <= pop ? head : '0;
            if (pop)  o_sample_cnt <= o_sample_cnt + 16'd1;
            // A zero stuff in the same cycle as a clear request keeps the flag set.
            if (tick && !pop)        o_underrun <= 1'b1;
            else if (i_clr_underrun) o_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: one DIV=4 and one DIV=1 instance,
// each fed by a show-ahead FIFO model.
module tb_fir_sample_feeder;

    localparam int WIDTH = 8;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             a_rst, a_empty, a_rd, a_valid, a_under, a_clr;
    logic [WIDTH-1:0] a_data, a_sample;
    logic [15:0]      a_cnt;
    logic             b_rst, b_empty, b_rd, b_valid, b_under, b_clr;
    logic [WIDTH-1:0] b_data, b_sample;
    logic [15:0]      b_cnt;

    fir_sample_feeder #(.WIDTH(WIDTH), .DIV(DIV_A)) dut_a (
        .i_clk          (clk),
        .i_rst          (a_rst),
        .i_fifo_data    (a_data),
        .i_fifo_empty   (a_empty),
        .o_fifo_rd_inc  (a_rd),
        .o_sample       (a_sample),
        .o_sample_valid (a_valid),
        .o_underrun     (a_under),
        .i_clr_underrun (a_clr),
        .o_sample_cnt   (a_cnt)
    );

    fir_sample_feeder #(.WIDTH(WIDTH), .DIV(DIV_B)) dut_b (
        .i_clk          (clk),
        .i_rst          (b_rst),
        .i_fifo_data    (b_data),
        .i_fifo_empty   (b_empty),
        .o_fifo_rd_inc  (b_rd),
        .o_sample       (b_sample),
        .o_sample_valid (b_valid),
        .o_underrun     (b_under),
        .i_clr_underrun (b_clr),
        .o_sample_cnt   (b_cnt)
    );

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] sb_a[$];
    logic [WIDTH-1:0] sb_b[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rel_cyc  = 0;
    int   a_last   = -1;
    int   a_first  = -1;
    int   b_last   = -1;
    int   b_first  = -1;
    logic a_seen   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_fifo();
        a_empty = (qa.size() == 0);
        a_data  = '0;
        if (qa.size() != 0) a_data = qa[0];
        b_empty = (qb.size() == 0);
        b_data  = '0;
        if (qb.size() != 0) b_data = qb[0];
    endtask

    // One clock: sample the read strobes mid-cycle, let the edge happen,
    // update the FIFO models and score any strobe.
    task automatic step();
        logic ra;
        logic rb;
        @(negedge clk);
        ra = a_rd;
        rb = b_rd;
        check("a_rd_while_empty", 32'(ra & a_empty), 32'd0);
        check("b_rd_while_empty", 32'(rb & b_empty), 32'd0);
        if (a_rst) check("a_rd_in_reset", 32'(ra), 32'd0);
        check("b_occ_le2", 32'(dut_b.occ <= 2'd2), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        if (ra) void'(qa.pop_front());
        if (rb) void'(qb.pop_front());
        drive_fifo();
        a_seen = a_valid;
        if (a_valid) begin
            check("a_strobe_expected", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) check("a_sample", 32'(a_sample), 32'(sb_a.pop_front()));
            if (a_first < 0) a_first = cyc;
            if (a_last >= 0) check("a_spacing", 32'(cyc - a_last), 32'(DIV_A));
            a_last = cyc;
        end
        if (b_valid) begin
            check("b_strobe_expected", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) check("b_sample", 32'(b_sample), 32'(sb_b.pop_front()));
            if (b_first < 0) b_first = cyc;
            if (b_last >= 0) check("b_spacing", 32'(cyc - b_last), 32'(DIV_B));
            b_last = cyc;
        end
    endtask

    task automatic wait_sb_a(input int left, input int budget);
        int n = 0;
        while (sb_a.size() > left && n < budget) begin
            step();
            n++;
        end
        check("a_drain", 32'(sb_a.size()), 32'(left));
    endtask

    task automatic wait_sb_b(input int left, input int budget);
        int n = 0;
        while (sb_b.size() > left && n < budget) begin
            step();
            n++;
        end
        check("b_drain", 32'(sb_b.size()), 32'(left));
    endtask

    task automatic release_a();
        a_rst   = 1'b0;
        rel_cyc = cyc;
        a_first = -1;
        a_last  = -1;
    endtask

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_clr = 1'b0;
        b_clr = 1'b0;

        // Reset with a non-empty FIFO, then a steady DIV=4 stream.
        for (int i = 1; i <= 10; i++) begin
            qa.push_back(WIDTH'(8'h11 * i));
            sb_a.push_back(WIDTH'(8'h11 * i));
        end
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_sample", 32'(a_sample), 32'd0);
            check("rst_valid", 32'(a_valid), 32'd0);
            check("rst_under", 32'(a_under), 32'd0);
            check("rst_cnt", 32'(a_cnt), 32'd0);
        end
        release_a();
        wait_sb_a(0, 80);
        check("stream_first_latency", 32'(a_first - rel_cyc), 32'(DIV_A + 2));
        check("stream_cnt", 32'(a_cnt), 32'd10);
        check("stream_under", 32'(a_under), 32'd0);
        a_rst = 1'b1;
        step();

        // Underrun: three words, then zero stuffing and clear/set priority.
        for (int i = 5; i <= 7; i++) begin
            qa.push_back(WIDTH'(i));
            sb_a.push_back(WIDTH'(i));
        end
        sb_a.push_back('0);
        drive_fifo();
        release_a();
        wait_sb_a(1, 40);
        check("under_before_stuff", 32'(a_under), 32'd0);
        wait_sb_a(0, 10);
        check("under_at_stuff", 32'(a_under), 32'd1);
        check("under_cnt", 32'(a_cnt), 32'd3);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_no_set", 32'(a_under), 32'd0);
        step();
        step();
        check("clr_stays_low", 32'(a_under), 32'd0);
        sb_a.push_back('0);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("stuff_strobe", 32'(a_seen), 32'd1);
        check("set_beats_clr", 32'(a_under), 32'd1);
        check("under_cnt_held", 32'(a_cnt), 32'd3);
        a_rst = 1'b1;
        step();

        // DIV=1 back-to-back burst.
        for (int i = 0; i < 16; i++) begin
            qb.push_back(WIDTH'(8'h80 + i * 7));
            sb_b.push_back(WIDTH'(8'h80 + i * 7));
        end
        drive_fifo();
        b_rst   = 1'b0;
        rel_cyc = cyc;
        wait_sb_b(0, 60);
        check("b_first_latency", 32'(b_first - rel_cyc), 32'(DIV_B + 2));
        check("b_cnt", 32'(b_cnt), 32'd16);
        check("b_under", 32'(b_under), 32'd0);
        b_rst = 1'b1;
        step();

        // Mid-run reset with a full buffer, then re-prime and counter wrap.
        for (int i = 0; i < 8; i++) qa.push_back(WIDTH'(8'h31 + i));
        sb_a.push_back(8'h31);
        drive_fifo();
        release_a();
        for (int i = 0; i < 8; i++) step();
        check("mid_occ", 32'(dut_a.occ), 32'd2);
        check("mid_pace", 32'(dut_a.pace), 32'd2);
        check("mid_sample", 32'(a_sample), 32'h31);
        check("mid_cnt", 32'(a_cnt), 32'd1);
        a_rst = 1'b1;
        step();
        check("mid_rst_sample", 32'(a_sample), 32'd0);
        check("mid_rst_cnt", 32'(a_cnt), 32'd0);
        check("mid_rst_valid", 32'(a_valid), 32'd0);
        check("mid_rst_occ", 32'(dut_a.occ), 32'd0);
        for (int i = 0; i < 5; i++) sb_a.push_back(WIDTH'(8'h34 + i));
        release_a();
        step();
        force dut_a.o_sample_cnt = 16'hFFFE;
        release dut_a.o_sample_cnt;
        wait_sb_a(4, 20);
        check("wrap_ffff", 32'(a_cnt), 32'hFFFF);
        wait_sb_a(3, 10);
        check("wrap_zero", 32'(a_cnt), 32'h0);
        wait_sb_a(2, 10);
        check("wrap_one", 32'(a_cnt), 32'h1);
        wait_sb_a(0, 20);
        check("reprime_latency", 32'(a_first - rel_cyc), 32'(DIV_A + 2));
        check("reprime_cnt", 32'(a_cnt), 32'h3);
        a_rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
